// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction ROM addressing and IF/ID register; optional perf counters under FETCH_PERF_EN
module fetch_stage #(
    parameter int          PC_W        = 12,
    parameter logic [4:0]  HALT_OPCODE = 5'b11111,
    parameter logic [18:0] NOP_INST    = 19'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [18:0]     imem_data,
    output logic [18:0]     IF_inst,
    output logic [PC_W-1:0] IF_pc_plus1,
    output logic            IF_valid,
    output logic            halted,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
);
    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pcp1_q, pcp1_d, pc_inc;
    logic [18:0]     inst_q, inst_d;
    logic            valid_q, valid_d;
    logic            fetch_en, is_halt_word;
    assign pc_inc       = pc_q + PC_W'(1);
    assign fetch_en     = (state_q == RUN) && !is_stall && !branch_taken;
    assign is_halt_word = imem_data[18:14] == HALT_OPCODE;
    assign imem_addr    = pc_q;
    assign IF_inst      = inst_q;
    assign IF_pc_plus1  = pcp1_q;
    assign IF_valid     = valid_q;
    assign halted       = state_q == HALTED;
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    // next state: a redirect always resumes running; fetching a HALT word parks the stage
    always_comb
        state_d = branch_taken ? RUN : (fetch_en && is_halt_word) ? HALTED : state_q;
    // datapath next values, priority flush > stall > halt-fetch > normal fetch
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        pcp1_d  = pcp1_q;
        valid_d = valid_q;
        if (branch_taken) begin
            pc_d    = branch_target;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (state_q == HALTED) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!is_stall) begin
            inst_d  = imem_data;
            pcp1_d  = pc_inc;
            valid_d = 1'b1;
            pc_d    = is_halt_word ? pc_q : pc_inc;
        end
    end
    // PC and IF/ID register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc_q    <= '0;
            pcp1_q  <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pcp1_q  <= pcp1_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
`ifdef FETCH_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    // saturating counters of stalled RUN cycles and redirects
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == RUN && is_stall && !branch_taken && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (branch_taken && flush_cnt_q != 16'hFFFF)
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule
